pipe_add_sub: RTL

PIPE_ADD_SUB -- requirements
Module: pipe_add_sub

---
 rtl/pipe_add_sub_pkg.sv | 14 +
 rtl/pipe_add_sub_seg.sv | 27 ++
 rtl/pipe_add_sub.sv | 116 +++++++++++
 3 files changed

// File: rtl/pipe_add_sub_pkg.sv
// Shared constants for the segmented add/subtract pipeline.
// Default width matches the project data width of 32 bits.
package pipe_add_sub_pkg;

  localparam int DEF_WIDTH = 32;

  localparam int DEF_SEGS = 4;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

endpackage

// File: rtl/pipe_add_sub_seg.sv
// One carry segment: W-bit ripple adder that also reports the carry into its MSB,
// so the last segment can derive signed overflow.
module add_sub_seg #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co,
  output logic         c_msb_in
);

  logic [W:0] c;

  always_comb begin
    c[0] = ci;
    for (int i = 0; i < W; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign co       = c[W];
  assign c_msb_in = c[W-1];

endmodule

// File: rtl/pipe_add_sub.sv
// Carry-segmented pipelined adder/subtractor: one SEG_W-bit segment resolved per
// stage, valid/ready handshake with a single global stall.
module pipe_add_sub
  import pipe_add_sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEGS  = DEF_SEGS
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             SnA,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] Y,
  output logic             CO,
  output logic             OV,
  output logic             ZERO
);

  localparam int SEG_W = WIDTH / SEGS;

  logic             stall;
  logic [WIDTH-1:0] aIn   [SEGS];
  logic [WIDTH-1:0] bIn   [SEGS];
  logic [WIDTH-1:0] sIn   [SEGS];
  logic [WIDTH-1:0] sNext [SEGS];
  logic             cIn   [SEGS];
  logic             vIn   [SEGS];
  logic             cNext [SEGS];
  logic             cMsb  [SEGS];

  logic [WIDTH-1:0] aQ [SEGS];
  logic [WIDTH-1:0] bQ [SEGS];
  logic [WIDTH-1:0] sQ [SEGS];
  logic             cQ [SEGS];
  logic             vQ [SEGS];
  logic             ovQ;
  logic             zeroQ;

  assign stall    = vQ[SEGS-1] & ~OUT_READY;
  assign IN_READY = ~stall;

  for (genvar k = 0; k < SEGS; k++) begin : gStage
    logic [SEG_W-1:0] segSum;
    logic [WIDTH-1:0] merged;

    if (k == 0) begin : gHead
      // Stage 0 sees the raw operands; IN_READY is high whenever it loads.
      assign aIn[k] = A;
      assign bIn[k] = B ^ {WIDTH{SnA}};
      assign sIn[k] = '0;
      assign cIn[k] = (op_e'(SnA) == OP_SUB);
      assign vIn[k] = IN_VALID;
    end else begin : gBody
      assign aIn[k] = aQ[k-1];
      assign bIn[k] = bQ[k-1];
      assign sIn[k] = sQ[k-1];
      assign cIn[k] = cQ[k-1];
      assign vIn[k] = vQ[k-1];
    end

    add_sub_seg #(.W(SEG_W)) uSeg (
      .a        (aIn[k][k*SEG_W +: SEG_W]),
      .b        (bIn[k][k*SEG_W +: SEG_W]),
      .ci       (cIn[k]),
      .s        (segSum),
      .co       (cNext[k]),
      .c_msb_in (cMsb[k])
    );

    // NOTE: full default before the partial overwrite keeps this purely combinational (no latch).
    always_comb begin
      merged                     = sIn[k];
      merged[k*SEG_W +: SEG_W]   = segSum;
    end

    assign sNext[k] = merged;
  end

  // NOTE: non-blocking assignments so every stage samples its predecessor's old value.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      // NOTE: datapath registers are cleared too because Y/CO/OV/ZERO must read zero in reset.
      for (int k = 0; k < SEGS; k++) begin
        vQ[k] <= 1'b0;
        cQ[k] <= 1'b0;
        sQ[k] <= '0;
        aQ[k] <= '0;
        bQ[k] <= '0;
      end
      ovQ   <= 1'b0;
      zeroQ <= 1'b0;
    end else if (!stall) begin
      for (int k = 0; k < SEGS; k++) begin
        vQ[k] <= vIn[k];
        cQ[k] <= cNext[k];
        sQ[k] <= sNext[k];
        aQ[k] <= aIn[k];
        bQ[k] <= bIn[k];
      end
      ovQ   <= cMsb[SEGS-1] ^ cNext[SEGS-1];
      zeroQ <= (sNext[SEGS-1] == '0);
    end
  end

  assign OUT_VALID = vQ[SEGS-1];
  assign Y         = sQ[SEGS-1];
  assign CO        = cQ[SEGS-1];
  assign OV        = ovQ;
  assign ZERO      = zeroQ;

endmodule
